// File: rtl/dm_unit_if.sv
// dm_unit_if: CPU-side access bus and store-monitor outputs of the data memory.
interface dm_unit_if;
  logic        MemWrite;
  logic [1:0]  DMOp;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] pc;
  logic [31:0] rdata;
  logic        wr_valid;
  logic [31:0] wr_pc;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        align_err;
  modport master (
    output MemWrite, DMOp, addr, wdata, pc,
    input  rdata, wr_valid, wr_pc, wr_addr, wr_data, align_err
  );
  modport slave (
    input  MemWrite, DMOp, addr, wdata, pc,
    output rdata, wr_valid, wr_pc, wr_addr, wr_data, align_err
  );
endinterface

// File: rtl/dm_unit.sv
// dm_unit: word/byte data memory with combinational reads, registered store monitor and misaligned-store flag.
module dm_unit #(
  parameter int ADDR_W    = 10,
  parameter bit INIT_ZERO = 1
) (
  input  logic  clk,
  input  logic  reset,
  dm_unit_if.slave bus
);
  localparam int WORDS = 1 << ADDR_W;
  logic [31:0]       mem_q [WORDS];
  logic [ADDR_W-1:0] idx;
  logic [1:0]        lane;
  logic [4:0]        sh;
  logic [31:0]       word, merged;
  logic [7:0]        rbyte;
  logic              we_w, we_b, we, mis;
  logic              wr_valid_q, wr_valid_d, align_q, align_d;
  logic [31:0]       wr_pc_q, wr_pc_d, wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
  assign idx   = bus.addr[ADDR_W+1:2];
  assign lane  = bus.addr[1:0];
  assign sh    = {lane, 3'b000};
  assign word  = mem_q[idx];
  assign rbyte = 8'(word >> sh);
  assign mis   = bus.MemWrite && bus.DMOp == 2'b00 && lane != 2'b00;
  assign we_w  = bus.MemWrite && bus.DMOp == 2'b00 && lane == 2'b00;
  assign we_b  = bus.DMOp == 2'b10;
  assign we    = we_w || we_b;
  // sb merges one lane into the current word; sw replaces it whole
  assign merged = we_b ? (word & ~(32'h0000_00FF << sh)) | ({24'b0, bus.wdata[7:0]} << sh)
                       : bus.wdata;
  always_comb begin
    bus.rdata = word;
    bus.rdata = bus.DMOp == 2'b00 ? (lane == 2'b00 ? word : 32'b0)
              : bus.DMOp == 2'b01 ? {{24{rbyte[7]}}, rbyte}
              : word;
  end
  always_comb begin
    wr_valid_d = we;
    wr_pc_d    = we ? bus.pc : wr_pc_q;
    wr_addr_d  = we ? {bus.addr[31:2], 2'b00} : wr_addr_q;
    wr_data_d  = we ? merged : wr_data_q;
    align_d    = mis;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_valid_q <= 1'b0;
      wr_pc_q    <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      align_q    <= 1'b0;
    end else begin
      wr_valid_q <= wr_valid_d;
      wr_pc_q    <= wr_pc_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      align_q    <= align_d;
    end
  end
  generate
    if (INIT_ZERO) begin : g_clr
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < WORDS; i++) mem_q[i] <= '0;
        end else if (we) begin
          mem_q[idx] <= merged;
        end
      end
    end else begin : g_keep
      // contents survive reset, but a store on a reset edge is still dropped
      always_ff @(posedge clk) begin
        if (we && !reset) mem_q[idx] <= merged;
      end
    end
  endgenerate
  assign bus.wr_valid  = wr_valid_q;
  assign bus.wr_pc     = wr_pc_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.align_err = align_q;
endmodule

// File: tb/tb_dm_unit.sv
// tb_dm_unit: directed-vector check of dm_unit loads, stores, monitor, alignment flag, wrap and reset.
module tb_dm_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_bad = 0;
  dm_unit_if bus ();
  dm_unit #(.ADDR_W(10), .INIT_ZERO(1)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic mw, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] p);
    bus.MemWrite = mw;
    bus.DMOp     = op;
    bus.addr     = a;
    bus.wdata    = d;
    bus.pc       = p;
    #1;
  endtask
  initial begin
    drive(1'b0, 2'b00, 32'h10, 32'h0, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_wr_valid", 32'(bus.wr_valid), 32'h0);
    chk("rst_align", 32'(bus.align_err), 32'h0);
    chk("rst_wr_data", bus.wr_data, 32'h0);
    drive(1'b1, 2'b00, 32'h20, 32'h12345678, 32'h400);
    chk("sw_rdw_old", bus.rdata, 32'h0);
    tick();
    drive(1'b0, 2'b00, 32'h20, 32'h0, 32'h404);
    chk("sw_valid", 32'(bus.wr_valid), 32'h1);
    chk("sw_addr", bus.wr_addr, 32'h20);
    chk("sw_data", bus.wr_data, 32'h12345678);
    chk("sw_pc", bus.wr_pc, 32'h400);
    chk("lw_20", bus.rdata, 32'h12345678);
    drive(1'b0, 2'b10, 32'h21, 32'hFFFFFFAB, 32'h408);
    tick();
    drive(1'b0, 2'b01, 32'h21, 32'h0, 32'h40C);
    chk("sb_valid", 32'(bus.wr_valid), 32'h1);
    chk("sb_data", bus.wr_data, 32'h1234AB78);
    chk("sb_addr", bus.wr_addr, 32'h20);
    chk("sb_pc", bus.wr_pc, 32'h408);
    chk("lb_21", bus.rdata, 32'hFFFFFFAB);
    drive(1'b0, 2'b01, 32'h20, 32'h0, 32'h40C);
    chk("lb_20", bus.rdata, 32'h00000078);
    tick();
    chk("idle_valid", 32'(bus.wr_valid), 32'h0);
    chk("idle_hold", bus.wr_data, 32'h1234AB78);
    drive(1'b1, 2'b00, 32'h22, 32'h55555555, 32'h410);
    chk("mis_rdata", bus.rdata, 32'h0);
    tick();
    drive(1'b0, 2'b00, 32'h20, 32'h0, 32'h414);
    chk("mis_align", 32'(bus.align_err), 32'h1);
    chk("mis_nowr", 32'(bus.wr_valid), 32'h0);
    chk("mis_mem", bus.rdata, 32'h1234AB78);
    tick();
    chk("mis_pulse", 32'(bus.align_err), 32'h0);
    drive(1'b1, 2'b01, 32'h20, 32'h99999999, 32'h418);
    tick();
    drive(1'b0, 2'b00, 32'h20, 32'h0, 32'h41C);
    chk("op01_nowr", 32'(bus.wr_valid), 32'h0);
    chk("op01_mem", bus.rdata, 32'h1234AB78);
    drive(1'b1, 2'b00, 32'h1000, 32'hDEADBEEF, 32'h420);
    tick();
    drive(1'b1, 2'b00, 32'h1004, 32'h00000001, 32'h424);
    chk("wrap_addr", bus.wr_addr, 32'h1000);
    chk("wrap_data", bus.wr_data, 32'hDEADBEEF);
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h428);
    chk("b2b_valid", 32'(bus.wr_valid), 32'h1);
    chk("b2b_addr", bus.wr_addr, 32'h1004);
    chk("wrap_lw0", bus.rdata, 32'hDEADBEEF);
    drive(1'b0, 2'b00, 32'h4, 32'h0, 32'h428);
    chk("wrap_lw4", bus.rdata, 32'h00000001);
    drive(1'b1, 2'b00, 32'h30, 32'hCAFEF00D, 32'h430);
    tick();
    drive(1'b1, 2'b00, 32'h34, 32'h0BADBEEF, 32'h434);
    chk("pre_rst_valid", 32'(bus.wr_valid), 32'h1);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.wr_valid), 32'h0);
    chk("arst_pc", bus.wr_pc, 32'h0);
    chk("arst_addr", bus.wr_addr, 32'h0);
    chk("arst_data", bus.wr_data, 32'h0);
    chk("arst_mem", bus.rdata, 32'h0);
    tick();
    drive(1'b0, 2'b00, 32'h20, 32'h0, 32'h0);
    reset = 1'b0;
    #1;
    chk("post_20", bus.rdata, 32'h0);
    drive(1'b0, 2'b00, 32'h34, 32'h0, 32'h0);
    chk("post_34", bus.rdata, 32'h0);
    chk("post_valid", 32'(bus.wr_valid), 32'h0);
    drive(1'b1, 2'b00, 32'h40, 32'h0F0F0F0F, 32'h500);
    tick();
    drive(1'b0, 2'b00, 32'h40, 32'h0, 32'h504);
    chk("first_valid", 32'(bus.wr_valid), 32'h1);
    chk("first_data", bus.wr_data, 32'h0F0F0F0F);
    chk("first_lw", bus.rdata, 32'h0F0F0F0F);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/dm_unit.md
Name: dm_unit

Overview:
- Data memory for the single-cycle CPU.
- Sits at the consuming end of the control-decode interface: takes the decoder's MemWrite and DMOp outputs plus the ALU address, and performs word and byte loads and stores.
- Provides a registered write-monitor port that reports each committed store one cycle after the edge. It also provides a registered alignment-error flag.

Parameters:
- ADDR_W, 10: log2 of the word count. 1024 words by default; word index is addr[ADDR_W+1:2].
- INIT_ZERO, 1: when 1, reset clears every memory word to 0. When 0, memory contents are untouched by reset; only the outputs reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- MemWrite  input  1  word-store enable from the decoder.
- DMOp  input  2  access size: 00 word, 01 byte load, 10 byte store, 11 reserved.
- addr  input  32  byte address from the ALU.
- wdata  input  32  store data (rt).
- pc  input  32  PC of the current instruction; used for the monitor only.
- rdata  output  32  load result; combinational.
- wr_valid  output  1  registered pulse: a store committed on the previous edge.
- wr_pc  output  32  PC of the committed store.
- wr_addr  output  32  word-aligned address of the committed store, {addr[31:2],2'b00}.
- wr_data  output  32  full post-write contents of that word.
- align_err  output  1  registered pulse: the previous cycle's word access was misaligned.

Behaviour:
- Word index:
  - idx = addr[ADDR_W+1:2].
  - Upper address bits are ignored, so access wraps modulo the memory size.
- Byte lane: lane = addr[1:0], little-endian. Byte k of a word is bits [8k+7:8k].
- Store enable:
  - we_w = MemWrite && DMOp==00 && addr[1:0]==00.
  - we_b = (DMOp==10) regardless of MemWrite. The decoder asserts DMOp=10 for sb without MemWrite.
  - A store with MemWrite=1 and DMOp==01 or 11 performs no write.
- Write timing:
  - Memory updates at posedge clk when we_w or we_b is set.
  - sb replaces only byte lane `lane` with wdata[7:0]; the other three bytes are preserved.
- Read (combinational from current memory):
  - DMOp 00, aligned: rdata = mem[idx].
  - DMOp 00, misaligned: rdata = 0.
  - DMOp 01: rdata = sign-extended byte lane `lane` of mem[idx].
  - DMOp 10 or 11: rdata = mem[idx]. The CPU does not use this value.
- Read-during-write: in the cycle of a store, rdata shows the pre-store contents; the new value is visible after the edge.
- Misalignment:
  - A word access is DMOp==00 with addr[1:0]!=0, plus either MemWrite=1 or a load in progress. A load counts as "in progress" whenever DMOp==00.
  - Flagged condition: DMOp==00 && addr[1:0]!=0 && MemWrite. Only misaligned stores are flagged, because the decoder always drives DMOp=00 on non-memory instructions.
  - Effect: align_err=1 for exactly the next cycle, and no write occurs.
- Monitor registers, each posedge:
  - wr_valid <= we_w||we_b.
  - When a store occurs: wr_pc <= pc, wr_addr <= word-aligned addr, wr_data <= merged word.
  - When no store occurs: wr_pc, wr_addr and wr_data hold their values.
- Back-to-back stores: each store produces its own one-cycle wr_valid pulse, with no merging. wr_valid stays high across consecutive store cycles.
- Reset (asynchronous, takes effect immediately):
  - wr_valid, wr_pc, wr_addr, wr_data and align_err are set to 0.
  - Memory is cleared to 0 when INIT_ZERO=1.
  - A store coinciding with the reset edge is discarded.
  - After release, the first store behaves normally.

Test Plan:
- Reset, then lw at addr 0x10 -> rdata=0x00000000; wr_valid=0 and align_err=0.
- sw 0x12345678 to 0x20 -> next cycle wr_valid=1, wr_addr=0x20, wr_data=0x12345678, wr_pc=pc. A following lw 0x20 reads 0x12345678.
- sb 0xAB to 0x21 with MemWrite=0 -> wr_data=0x1234AB78. lb 0x21 -> 0xFFFFFFAB; lb 0x20 -> 0x00000078.
- sw with MemWrite=1, DMOp=00 to 0x22 -> no write, align_err=1 for one cycle. Word 0x20 is still 0x1234AB78.
- Address wrap: sw 0xDEADBEEF to 0x1000 (ADDR_W=10) -> lw 0x0000 reads 0xDEADBEEF, and wr_addr=0x1000.
- Assert reset mid-sequence, between two sw edges -> all outputs read 0 immediately, and the memory reads 0 after release.
